// File: rtl/mesi_isc_cpu_stat_mon.sv
// Per-CPU NOP/RD/WR access counters with snapshot shadow bank and an inactivity watchdog.
// Optional macro MESI_ISC_STAT_SAT_EN makes all counters saturate instead of wrapping.

`ifndef MESI_ISC_TB_INS_NOP
`define MESI_ISC_TB_INS_NOP 4'd0
`endif
`ifndef MESI_ISC_TB_INS_WR
`define MESI_ISC_TB_INS_WR 4'd1
`endif
`ifndef MESI_ISC_TB_INS_RD
`define MESI_ISC_TB_INS_RD 4'd2
`endif

module mesi_isc_cpu_stat_mon #(
    parameter int NUM_CPUS    = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int TOT_WIDTH   = 36,
    parameter int WDOG_CYCLES = 20000,
    parameter int SEL_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CPUS-1:0]   tb_ins_ack,
    input  logic [4*NUM_CPUS-1:0] tb_ins,
    input  logic                  snap_req,
    input  logic                  snap_clr,
    output logic                  snap_ack,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [TOT_WIDTH-1:0]  rd_data,
    input  logic                  wdog_start,
    input  logic                  wdog_clr,
    output logic                  wdog_expired,
    output logic [1:0]            wdog_state
);

    localparam int WCW = $clog2(WDOG_CYCLES);
    localparam logic [WCW-1:0] WDOG_RELOAD = WCW'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_RUN     = 2'd1,
        WD_EXPIRED = 2'd2
    } wdog_state_t;

    logic [CNT_WIDTH-1:0] nop_cnt [NUM_CPUS];
    logic [CNT_WIDTH-1:0] rd_cnt  [NUM_CPUS];
    logic [CNT_WIDTH-1:0] wr_cnt  [NUM_CPUS];
    logic [TOT_WIDTH-1:0] tot_cnt;

    logic [CNT_WIDTH-1:0] sh_nop [NUM_CPUS];
    logic [CNT_WIDTH-1:0] sh_rd  [NUM_CPUS];
    logic [CNT_WIDTH-1:0] sh_wr  [NUM_CPUS];
    logic [TOT_WIDTH-1:0] sh_tot;

    logic [NUM_CPUS-1:0]  nop_hit;
    logic [NUM_CPUS-1:0]  rd_hit;
    logic [NUM_CPUS-1:0]  wr_hit;
    logic [TOT_WIDTH-1:0] rw_sum;
    logic                 any_rw;
    logic                 clear_live;
    logic [TOT_WIDTH-1:0] rd_mux;

    wdog_state_t          state, next_state;
    logic [WCW-1:0]       wdog_cnt, next_wdog_cnt;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] base,
                                                      input logic inc);
`ifdef MESI_ISC_STAT_SAT_EN
        cnt_next = (inc && (base != '1)) ? base + CNT_WIDTH'(1'b1) : base;
`else
        cnt_next = base + CNT_WIDTH'(inc);
`endif
    endfunction

    function automatic logic [TOT_WIDTH-1:0] tot_next(input logic [TOT_WIDTH-1:0] base,
                                                      input logic [TOT_WIDTH-1:0] add);
`ifdef MESI_ISC_STAT_SAT_EN
        logic [TOT_WIDTH:0] sum;
        sum      = {1'b0, base} + {1'b0, add};
        tot_next = sum[TOT_WIDTH] ? '1 : sum[TOT_WIDTH-1:0];
`else
        tot_next = base + add;
`endif
    endfunction

    always_comb begin
        nop_hit = '0;
        rd_hit  = '0;
        wr_hit  = '0;
        rw_sum  = '0;
        for (int p = 0; p < NUM_CPUS; p++) begin
            if (tb_ins_ack[p]) begin
                case (tb_ins[4*p +: 4])
                    `MESI_ISC_TB_INS_NOP: nop_hit[p] = 1'b1;
                    `MESI_ISC_TB_INS_RD:  rd_hit[p]  = 1'b1;
                    `MESI_ISC_TB_INS_WR:  wr_hit[p]  = 1'b1;
                    default: ;
                endcase
            end
            rw_sum = rw_sum + TOT_WIDTH'(rd_hit[p]) + TOT_WIDTH'(wr_hit[p]);
        end
    end

    assign any_rw     = |(rd_hit | wr_hit);
    assign clear_live = snap_req & snap_clr;

    // A clearing capture restarts from zero but still keeps this cycle's events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_CPUS; p++) begin
                nop_cnt[p] <= '0;
                rd_cnt[p]  <= '0;
                wr_cnt[p]  <= '0;
            end
            tot_cnt <= '0;
        end else begin
            for (int p = 0; p < NUM_CPUS; p++) begin
                nop_cnt[p] <= cnt_next(clear_live ? '0 : nop_cnt[p], nop_hit[p]);
                rd_cnt[p]  <= cnt_next(clear_live ? '0 : rd_cnt[p],  rd_hit[p]);
                wr_cnt[p]  <= cnt_next(clear_live ? '0 : wr_cnt[p],  wr_hit[p]);
            end
            tot_cnt <= tot_next(clear_live ? '0 : tot_cnt, rw_sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_CPUS; p++) begin
                sh_nop[p] <= '0;
                sh_rd[p]  <= '0;
                sh_wr[p]  <= '0;
            end
            sh_tot   <= '0;
            snap_ack <= 1'b0;
            rd_data  <= '0;
        end else begin
            snap_ack <= snap_req;
            rd_data  <= rd_mux;
            if (snap_req) begin
                for (int p = 0; p < NUM_CPUS; p++) begin
                    sh_nop[p] <= nop_cnt[p];
                    sh_rd[p]  <= rd_cnt[p];
                    sh_wr[p]  <= wr_cnt[p];
                end
                sh_tot <= tot_cnt;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_CPUS; p++) begin
            if (int'(rd_sel) == 3*p)     rd_mux = TOT_WIDTH'(sh_nop[p]);
            if (int'(rd_sel) == 3*p + 1) rd_mux = TOT_WIDTH'(sh_rd[p]);
            if (int'(rd_sel) == 3*p + 2) rd_mux = TOT_WIDTH'(sh_wr[p]);
        end
        if (int'(rd_sel) == 3*NUM_CPUS) rd_mux = sh_tot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WD_IDLE;
            wdog_cnt <= '0;
        end else begin
            state    <= next_state;
            wdog_cnt <= next_wdog_cnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_wdog_cnt = wdog_cnt;
        if (wdog_clr) begin
            next_state    = WD_IDLE;
            next_wdog_cnt = '0;
        end else begin
            case (state)
                WD_IDLE: begin
                    if (wdog_start) begin
                        next_state    = WD_RUN;
                        next_wdog_cnt = WDOG_RELOAD;
                    end
                end
                WD_RUN: begin
                    if (wdog_start || any_rw) begin
                        next_wdog_cnt = WDOG_RELOAD;
                    end else if (wdog_cnt == '0) begin
                        next_state = WD_EXPIRED;
                    end else begin
                        next_wdog_cnt = wdog_cnt - WCW'(1'b1);
                    end
                end
                WD_EXPIRED: ;
                default: begin
                    next_state    = WD_IDLE;
                    next_wdog_cnt = '0;
                end
            endcase
        end
    end

    assign wdog_expired = (state == WD_EXPIRED);
    assign wdog_state   = state;

endmodule
